// File: rtl/prog_loader.sv
// prog_loader
// -----------
// Byte-stream program loader for the accumulator CPU core. Framed bytes arrive
// over a valid/ready stream and are written into the core's instruction or
// data memory while the core is held in reset. A "go" header releases the
// core. When the core raises HALT, the loader takes it back into reset so the
// next program can be loaded.
//
// Frame format: header, length L (1..2**ADDR_W), L payload bytes, checksum.
// The 8-bit wrap-around sum of every byte in the frame, checksum included,
// must be zero.
// Header byte: bit7 = target memory (0 ins / 1 data), bit6 = go,
//              bit5 = clear-err, bits[4:0] = start address.
//
// Handshake: a byte transfers on a rising clk edge where in_valid & in_ready.
// in_ready depends only on state, never on in_valid. When in_valid is low,
// nothing changes.
//
// Ports:
//   clk, rst    system clock; asynchronous active-high reset
//   in_valid    stream byte valid
//   in_data     stream byte
//   in_ready    loader can accept a byte (low only while the core runs)
//   mem_we      one-cycle write strobe, registered, one per payload byte
//   mem_sel     0 = instruction memory, 1 = data memory
//   mem_addr    write address
//   mem_wdata   write data
//   cpu_rst     reset to the core, 1 = core held
//   cpu_halt    core HALT output (only looked at while the core runs)
//   running     core released
//   err         sticky frame error (bad length or bad checksum)
//   done        sticky: core has halted since the last go

module prog_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    output logic              running,
    output logic              err,
    output logic              done
);

    // The length field is one bit wider than an address so that a full-depth
    // frame (L = 2**ADDR_W) can be expressed.
    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_RUN  = 3'd4
    } state_t;

    state_t state, state_n;

    logic              sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  count_q;
    logic [DATA_W-1:0] sum_q;

    logic              fire;
    logic [LEN_W-1:0]  len_val;
    logic              len_bad;
    logic [DATA_W-1:0] sum_next;

    // Decoded events for the datapath register block.
    logic go_accept;
    logic clr_accept;
    logic hdr_accept;
    logic len_ok;
    logic len_err;
    logic data_accept;
    logic csum_err;
    logic halt_seen;

    assign in_ready = (state != S_RUN);
    assign running  = (state == S_RUN);
    assign cpu_rst  = (state != S_RUN);

    assign fire     = in_valid & in_ready;
    assign len_val  = in_data[ADDR_W:0];
    assign len_bad  = (len_val == '0) || (len_val > DEPTH);
    assign sum_next = sum_q + in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        go_accept   = 1'b0;
        clr_accept  = 1'b0;
        hdr_accept  = 1'b0;
        len_ok      = 1'b0;
        len_err     = 1'b0;
        data_accept = 1'b0;
        csum_err    = 1'b0;
        halt_seen   = 1'b0;
        case (state)
            S_IDLE: begin
                if (fire) begin
                    if (in_data[DATA_W-2]) begin
                        // A go header is refused while an error is pending.
                        if (!err) begin
                            go_accept = 1'b1;
                            state_n   = S_RUN;
                        end
                    end else if (in_data[DATA_W-3]) begin
                        clr_accept = 1'b1;
                    end else begin
                        hdr_accept = 1'b1;
                        state_n    = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (fire) begin
                    if (len_bad) begin
                        len_err = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        len_ok  = 1'b1;
                        state_n = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    data_accept = 1'b1;
                    if (count_q == LEN_W'(1)) begin
                        state_n = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (fire) begin
                    csum_err = (sum_next != '0);
                    state_n  = S_IDLE;
                end
            end
            S_RUN: begin
                if (cpu_halt) begin
                    halt_seen = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= 1'b0;
            addr_q    <= '0;
            count_q   <= '0;
            sum_q     <= '0;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= data_accept;

            if (hdr_accept) begin
                sel_q  <= in_data[DATA_W-1];
                addr_q <= in_data[ADDR_W-1:0];
                sum_q  <= in_data;
            end

            if (len_ok) begin
                count_q <= len_val;
                sum_q   <= sum_next;
            end

            if (data_accept) begin
                mem_sel   <= sel_q;
                mem_addr  <= addr_q;
                mem_wdata <= in_data;
                // Address wraps naturally at 2**ADDR_W.
                addr_q    <= addr_q + ADDR_W'(1);
                count_q   <= count_q - LEN_W'(1);
                sum_q     <= sum_next;
            end

            if (len_err || csum_err) begin
                err <= 1'b1;
            end else if (clr_accept) begin
                err <= 1'b0;
            end

            if (go_accept) begin
                done <= 1'b0;
            end else if (halt_seen) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader. A frame-level model follows every accepted byte
// (position within the frame, running sum, expected write list). A negedge
// process compares the DUT outputs against that model on every cycle.
// Hand-computed literal checks after each scenario pin the model itself.

module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       cpu_halt = 1'b0;
    logic       in_ready;
    logic       mem_we;
    logic       mem_sel;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst;
    logic       running;
    logic       err;
    logic       done;

    prog_loader #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .cpu_halt  (cpu_halt),
        .running   (running),
        .err       (err),
        .done      (done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    logic [13:0] exp_q[$];   // {sel, addr[4:0], data[7:0]}
    int          wr_cyc[$];
    logic [7:0]  ins_seen[32];
    logic [7:0]  data_seen[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_running = 1'b0;
    bit m_err     = 1'b0;
    bit m_done    = 1'b0;
    int m_pos     = 0;    // bytes consumed in the current frame
    int m_len     = 0;
    int m_base    = 0;
    bit m_sel     = 1'b0;
    int m_sum     = 0;

    function automatic void model_reset();
        m_running = 1'b0;
        m_err     = 1'b0;
        m_done    = 1'b0;
        m_pos     = 0;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int l;
        if (m_pos == 0) begin
            if (b[6]) begin
                if (!m_err) begin
                    m_running = 1'b1;
                    m_done    = 1'b0;
                end
            end else if (b[5]) begin
                m_err = 1'b0;
            end else begin
                m_sel  = b[7];
                m_base = int'(b[4:0]);
                m_sum  = int'(b);
                m_pos  = 1;
            end
        end else if (m_pos == 1) begin
            l = int'(b[5:0]);
            if (l == 0 || l > 32) begin
                m_err = 1'b1;
                m_pos = 0;
            end else begin
                m_len = l;
                m_sum += int'(b);
                m_pos = 2;
            end
        end else if (m_pos < m_len + 2) begin
            exp_q.push_back({m_sel, 5'((m_base + m_pos - 2) % 32), b});
            m_sum += int'(b);
            m_pos++;
        end else begin
            m_sum += int'(b);
            if ((m_sum % 256) != 0) m_err = 1'b1;
            m_pos = 0;
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [13:0] e;
        check("in_ready", 32'(in_ready), 32'(!m_running));
        check("cpu_rst",  32'(cpu_rst),  32'(!m_running));
        check("running",  32'(running),  32'(m_running));
        check("err",      32'(err),      32'(m_err));
        check("done",     32'(done),     32'(m_done));
        check("mem_we",   32'(mem_we),   32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (mem_we === 1'b1)
                check("mem_write", 32'({mem_sel, mem_addr, mem_wdata}), 32'(e));
        end
        if (mem_we === 1'b1) begin
            wr_cyc.push_back(cyc);
            if (mem_sel) data_seen[mem_addr] = mem_wdata;
            else         ins_seen[mem_addr]  = mem_wdata;
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic send(input logic [7:0] b);
        bit acc;
        in_valid = 1'b1;
        in_data  = b;
        acc      = !m_running;
        @(posedge clk);
        #1;
        if (acc) model_byte(b);
    endtask

    task automatic stop(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic halt_pulse();
        cpu_halt = 1'b1;
        @(posedge clk);
        #1;
        if (m_running) begin
            m_running = 1'b0;
            m_done    = 1'b1;
        end
        cpu_halt = 1'b0;
    endtask

    task automatic reset_literals(input string tag);
        check({tag, "_cpu_rst"},   32'(cpu_rst),   32'd1);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_sel"},   32'(mem_sel),   32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_running"},   32'(running),   32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] s;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_literals("por");
        rst = 1'b0;
        stop(1);

        // Load: sum 00+03+A1+B2+C3 = 0x19, checksum 0xE7.
        wr_cyc.delete();
        send(8'h00); send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3); send(8'hE7);
        stop(1);
        check("load_nwrites", 32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() == 3) begin
            check("load_consec1", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
            check("load_consec2", 32'(wr_cyc[2] - wr_cyc[1]), 32'd1);
        end
        check("load_ins0", 32'(ins_seen[0]), 32'hA1);
        check("load_ins1", 32'(ins_seen[1]), 32'hB2);
        check("load_ins2", 32'(ins_seen[2]), 32'hC3);
        check("load_err",  32'(err), 32'd0);

        // Wrap with stalls: 9E+03+01+02+03 = 0xA7, checksum 0x59.
        send(8'h9E); send(8'h03);
        stop(2);
        send(8'h01); send(8'h02);
        stop(1);
        send(8'h03); send(8'h59);
        stop(1);
        check("wrap_d30", 32'(data_seen[30]), 32'h01);
        check("wrap_d31", 32'(data_seen[31]), 32'h02);
        check("wrap_d0",  32'(data_seen[0]),  32'h03);
        check("wrap_err", 32'(err), 32'd0);

        // Bad checksum, refused go, clear, accepted go.
        wr_cyc.delete();
        send(8'h00); send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3); send(8'h00);
        stop(1);
        check("bad_nwrites", 32'(wr_cyc.size()), 32'd3);
        check("bad_err", 32'(err), 32'd1);
        send(8'h40); stop(1);
        check("refused_cpu_rst", 32'(cpu_rst), 32'd1);
        send(8'h20); stop(1);
        check("cleared_err", 32'(err), 32'd0);
        send(8'h40);
        check("go_cpu_rst", 32'(cpu_rst), 32'd0);
        check("go_running", 32'(running), 32'd1);
        check("go_in_ready", 32'(in_ready), 32'd0);

        // Bytes offered during RUN are not accepted.
        wr_cyc.delete();
        send(8'h00); send(8'h03); send(8'h11);
        stop(1);
        check("run_nwrites", 32'(wr_cyc.size()), 32'd0);
        check("run_still", 32'(running), 32'd1);
        halt_pulse();
        check("halt_cpu_rst",  32'(cpu_rst),  32'd1);
        check("halt_done",     32'(done),     32'd1);
        check("halt_in_ready", 32'(in_ready), 32'd1);
        // HALT outside RUN changes nothing.
        halt_pulse();
        stop(1);
        check("halt_idle_cpu_rst", 32'(cpu_rst), 32'd1);

        // Length errors: L=0 and L=33.
        wr_cyc.delete();
        send(8'h00); send(8'h00); stop(1);
        check("len0_err", 32'(err), 32'd1);
        send(8'h20); stop(1);
        send(8'h00); send(8'h21); stop(1);
        check("len33_err", 32'(err), 32'd1);
        check("len_nwrites", 32'(wr_cyc.size()), 32'd0);
        send(8'h20); stop(1);

        // Full-depth frame: L=32 into data memory from address 0.
        wr_cyc.delete();
        s = 8'h80 + 8'h20;
        send(8'h80); send(8'h20);
        for (int i = 0; i < 32; i++) begin
            send(8'(i) ^ 8'h5A);
            s = s + (8'(i) ^ 8'h5A);
        end
        send(8'h00 - s);
        stop(1);
        check("full_nwrites", 32'(wr_cyc.size()), 32'd32);
        check("full_d31", 32'(data_seen[31]), 32'h45);
        check("full_err", 32'(err), 32'd0);

        // Reset mid-frame after two payload bytes.
        send(8'h00); send(8'h03); send(8'h11); send(8'h22);
        stop(1);
        rst = 1'b1;
        model_reset();
        #1;
        reset_literals("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        stop(1);
        // 03+11+22+33 = 0x69, checksum 0x97.
        send(8'h00); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
        stop(1);
        check("reload_ins2", 32'(ins_seen[2]), 32'h33);
        check("reload_err",  32'(err), 32'd0);

        stop(2);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
